// File: rtl/handshake_pkg.sv
// Shared definitions for the 4-phase req/ack CDC responder and its synchronizer.
package handshake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESENT  = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/handshake_rx_if.sv
// Bundle of the initiator-facing req/ack/data lines and the local valid/ready consumer port.
interface handshake_rx_if #(
  parameter int DATA_W = 8
);
  import handshake_pkg::*;

  logic              req_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              busy;
  logic              proto_err;
  state_t            state;

  // master: environment (initiator + consumer); slave: the responder itself.
  modport master (
    output req_in, data_in, data_ready,
    input  ack_out, data_out, data_valid, busy, proto_err, state
  );

  modport slave (
    input  req_in, data_in, data_ready,
    output ack_out, data_out, data_valid, busy, proto_err, state
  );

endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; resets to 0.
module bit_sync
  import handshake_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Fewer than two flops gives no metastability settling time, so clamp up.
  localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= '0;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/handshake_rx.sv
// Receiving side of a 4-phase req/ack CDC handshake: synchronizes req, captures the
// word, hands it to a local valid/ready consumer, then runs the ack return-to-zero.
module handshake_rx
  import handshake_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  handshake_rx_if.slave bus
);

  logic              req_s;
  state_t            state_q, state_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.req_in),
    .q   (req_s)
  );

  // Consumer side: a word moves on a rising edge where data_valid and data_ready are
  // both 1; data_valid never drops and data_out never changes until that edge.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        if (req_s) begin
          data_d  = bus.data_in;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // Initiator withdrew req before we acked: flag it, but still deliver the word.
        if (!req_s) err_d = 1'b1;
        if (bus.data_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.ack_out    = ack_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.proto_err  = err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_handshake_rx.sv
// Bench for handshake_rx: fixed latency tables, corner-case sequences, and a randomized
// slow initiator / random consumer run scored against an expected-word queue.
module tb_handshake_rx;
  import handshake_pkg::*;

  logic clk;
  logic rst;

  handshake_rx_if #(.DATA_W(8))  hs8 ();
  handshake_rx_if #(.DATA_W(32)) hs32 ();

  handshake_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (hs8)
  );

  handshake_rx #(.DATA_W(32), .SYNC_STAGES(3)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (hs32)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard
  logic [7:0] exp_q[$];
  int sent = 0;
  int seen = 0;
  bit init_done = 1'b0;

  // Initiator in a foreign domain: period 74 = 3.7x clk, phase kept on odd times so it
  // never lines up with a clk edge.
  localparam int INIT_T = 74;

  task automatic init_send(input logic [7:0] w);
    int n;
    hs8.data_in = w;
    hs8.req_in  = 1'b1;
    exp_q.push_back(w);
    sent++;
    n = 0;
    while (hs8.ack_out !== 1'b1 && n < 300) begin
      #(INIT_T);
      n++;
    end
    chk("init_ack_rise_in_bound", 64'(n < 300), 64'd1);
    #(INIT_T * $urandom_range(1, 2));
    hs8.req_in = 1'b0;
    n = 0;
    while (hs8.ack_out !== 1'b0 && n < 300) begin
      #(INIT_T);
      n++;
    end
    chk("init_ack_fall_in_bound", 64'(n < 300), 64'd1);
    hs8.data_in = 8'($urandom);
    #(INIT_T * $urandom_range(1, 3));
  endtask

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic       ready;
    logic       exp_valid;
    logic       exp_ack;
    logic       exp_busy;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n;
    // Row k: inputs applied just before edge k+1, outputs expected just after it.
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5};
    tbl[3] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[4] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[5] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[6] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[7] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[8] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};

    rst = 1'b0;
    hs8.req_in = 1'b0;  hs8.data_in = '0;  hs8.data_ready = 1'b0;
    hs32.req_in = 1'b0; hs32.data_in = '0; hs32.data_ready = 1'b0;
    repeat (3) tick();

    chk("reset_ack", hs8.ack_out, 0);
    chk("reset_valid", hs8.data_valid, 0);
    chk("reset_data", hs8.data_out, 0);
    chk("reset_busy", hs8.busy, 0);
    chk("reset_err", hs8.proto_err, 0);
    chk("reset_state", hs8.state, ST_IDLE);
    rst = 1'b1;
    tick();

    // Single transfer, ready held high
    for (int k = 0; k < 9; k++) begin
      hs8.req_in     = tbl[k].req;
      hs8.data_in    = tbl[k].data;
      hs8.data_ready = tbl[k].ready;
      tick();
      chk($sformatf("single_e%0d_valid", k + 1), hs8.data_valid, tbl[k].exp_valid);
      chk($sformatf("single_e%0d_ack", k + 1), hs8.ack_out, tbl[k].exp_ack);
      chk($sformatf("single_e%0d_busy", k + 1), hs8.busy, tbl[k].exp_busy);
      chk($sformatf("single_e%0d_data", k + 1), hs8.data_out, tbl[k].exp_data);
    end

    // Consumer stall for 10 cycles
    hs8.req_in = 1'b1; hs8.data_in = 8'hC3; hs8.data_ready = 1'b0;
    repeat (3) tick();
    chk("stall_valid_e3", hs8.data_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("stall_c%0d_valid", i), hs8.data_valid, 1);
      chk($sformatf("stall_c%0d_data", i), hs8.data_out, 8'hC3);
      chk($sformatf("stall_c%0d_ack", i), hs8.ack_out, 0);
    end
    hs8.data_ready = 1'b1;
    tick();
    chk("stall_release_ack", hs8.ack_out, 1);
    chk("stall_release_valid", hs8.data_valid, 0);
    hs8.req_in = 1'b0; hs8.data_ready = 1'b0;
    n = 0;
    while (hs8.ack_out !== 1'b0 && n < 8) begin tick(); n++; end
    chk("stall_ack_fall_cycles", n, 3);
    chk("stall_busy_end", hs8.busy, 0);

    // Back-to-back: 01,02,03 then random words, random consumer readiness
    fork
      begin
        #1;
        init_send(8'h01);
        init_send(8'h02);
        init_send(8'h03);
        for (int i = 0; i < 6; i++) init_send(8'($urandom_range(0, 255)));
        init_done = 1'b1;
      end
      begin
        int cyc = 0;
        while (!(init_done && exp_q.size() == 0) && cyc < 6000) begin
          @(negedge clk);
          cyc++;
          hs8.data_ready = ($urandom_range(0, 3) != 0);
          if (hs8.data_valid && hs8.data_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL b2b_unexpected_word actual=%0h required=none", hs8.data_out);
            end else begin
              chk($sformatf("b2b_word%0d", seen), hs8.data_out, exp_q.pop_front());
            end
            seen++;
          end
        end
        chk("b2b_drain_in_bound", 64'(cyc < 6000), 64'd1);
      end
    join
    @(negedge clk);
    hs8.data_ready = 1'b0;
    chk("b2b_count", seen, sent);
    chk("b2b_proto_err", hs8.proto_err, 0);
    repeat (4) tick();
    chk("b2b_idle", hs8.busy, 0);

    // Protocol violation: req only 3 cycles, consumer not ready
    hs8.req_in = 1'b1; hs8.data_in = 8'h3C; hs8.data_ready = 1'b0;
    repeat (3) tick();
    hs8.req_in = 1'b0;
    repeat (4) tick();
    chk("viol_err_set", hs8.proto_err, 1);
    chk("viol_valid_held", hs8.data_valid, 1);
    chk("viol_data", hs8.data_out, 8'h3C);
    chk("viol_ack_low", hs8.ack_out, 0);
    hs8.data_ready = 1'b1;
    tick();
    chk("viol_ack_high", hs8.ack_out, 1);
    chk("viol_valid_done", hs8.data_valid, 0);
    tick();
    chk("viol_ack_one_cycle", hs8.ack_out, 0);
    chk("viol_busy_end", hs8.busy, 0);
    hs8.data_ready = 1'b0;
    repeat (3) tick();
    chk("viol_err_sticky", hs8.proto_err, 1);

    // Reset mid-transfer in WAIT_LOW, released with req still high
    hs8.req_in = 1'b1; hs8.data_in = 8'h77; hs8.data_ready = 1'b1;
    n = 0;
    while (hs8.ack_out !== 1'b1 && n < 10) begin tick(); n++; end
    chk("rstmid_reach_wait_low", hs8.state, ST_WAIT_LOW);
    hs8.data_ready = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk("rstmid_ack_async", hs8.ack_out, 0);
    chk("rstmid_valid_async", hs8.data_valid, 0);
    chk("rstmid_busy_async", hs8.busy, 0);
    chk("rstmid_err_cleared", hs8.proto_err, 0);
    hs8.data_in = 8'h88;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) tick();
    chk("rstmid_valid_e2", hs8.data_valid, 0);
    tick();
    chk("rstmid_valid_e3", hs8.data_valid, 1);
    chk("rstmid_data_e3", hs8.data_out, 8'h88);
    hs8.req_in = 1'b0; hs8.data_ready = 1'b1;
    n = 0;
    while (hs8.busy !== 1'b0 && n < 10) begin tick(); n++; end
    chk("rstmid_cleanup_idle", hs8.busy, 0);
    hs8.data_ready = 1'b0;

    // Three-stage synchronizer, 32-bit word
    hs32.req_in = 1'b1; hs32.data_in = 32'hDEADBEEF; hs32.data_ready = 1'b0;
    repeat (3) tick();
    chk("w32_valid_e3", hs32.data_valid, 0);
    tick();
    chk("w32_valid_e4", hs32.data_valid, 1);
    chk("w32_data_e4", hs32.data_out, 32'hDEADBEEF);
    hs32.data_ready = 1'b1;
    tick();
    chk("w32_ack_e5", hs32.ack_out, 1);
    hs32.req_in = 1'b0; hs32.data_ready = 1'b0;
    n = 0;
    while (hs32.ack_out !== 1'b0 && n < 10) begin tick(); n++; end
    chk("w32_ack_fall_cycles", n, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/handshake_rx.md
Name: handshake_rx

Overview:
- Destination-side responder of a 4-phase req/ack clock-domain-crossing handshake carrying a DATA_W-bit word.
- The initiator sits in a foreign clock domain. It drives req_in and data_in, and holds data_in stable from req_in rise until it sees ack_out high.
- This block synchronizes req_in into clk and captures the word. It presents the word to a local valid/ready consumer, then completes the ack/req return-to-zero sequence.
- It complements the fast-to-slow pulse synchronizer wherever a multi-bit payload must cross domains.

Parameters:
- DATA_W, 8, width of transferred word (1..64).
- SYNC_STAGES, 2, number of flops in the req_in synchronizer (2..4).

Ports:
- clk  in  1  local (receiving-domain) clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_in  in  1  request from initiator; asynchronous to clk.
- data_in  in  DATA_W  payload from initiator; quasi-static while req_in high and ack_out low.
- ack_out  out  1  acknowledge to initiator; registered, glitch-free.
- data_out  out  DATA_W  captured word.
- data_valid  out  1  data_out holds an unconsumed word.
- data_ready  in  1  local consumer accepts the word.
- busy  out  1  high whenever state != IDLE.
- proto_err  out  1  sticky; initiator dropped req_in before ack_out was raised.

Behaviour:
- Reset (rst low, async): synchronizer flops=0, state=IDLE, ack_out=0, data_out=0, data_valid=0, busy=0, proto_err=0. Reset mid-transfer abandons the word; ack_out falls immediately.
- req_s = output of the SYNC_STAGES flop chain on req_in, reset to 0. data_in is never synchronized; it is sampled only when req_s=1 in IDLE.
- FSM states:
  - IDLE: if req_s=1 -> data_out<=data_in, data_valid<=1, go to PRESENT.
  - PRESENT: data_valid=1, data_out frozen. On an edge with data_ready=1 -> data_valid<=0, ack_out<=1, go to WAIT_LOW. data_ready may already be high on entry; the earliest transfer is the first PRESENT edge.
  - WAIT_LOW: ack_out=1. If req_s=0 -> ack_out<=0, go to IDLE.
- Latency with SYNC_STAGES=2, req_in rising just before edge 1:
  - req_s=1 after edge 2.
  - data_valid=1 after edge 3.
  - With data_ready held high, ack_out=1 after edge 4.
  - req_in falling just before edge k gives ack_out=0 after edge k+2.
- Back-to-back transfers: after IDLE is re-entered, a new req_s=1 is captured on the next edge. Minimum IDLE dwell is 1 cycle.
- Protocol violation: req_s=0 observed while in PRESENT sets proto_err<=1, cleared only by reset. The transfer still completes. WAIT_LOW then sees req_s=0 and drops ack_out after 1 cycle.
- req_in already high at reset release: treated as a new request once it propagates through the synchronizer.
- data_ready while not PRESENT: ignored.
- Encoding: state is 2 bits; the unused code recovers to IDLE with ack_out=0. ack_out is driven directly from a flop, never combinationally.

Decomposition:
- Shared package handshake_pkg: state encodings ST_IDLE=2'd0, ST_PRESENT=2'd1, ST_WAIT_LOW=2'd2; SYNC_STAGES_MIN=2.
- One sub-module: bit_sync (parameterized SYNC_STAGES flop chain, async active-low reset to 0), instantiated for req_in.
- The same bit_sync is reused by the future initiator block for ack.

Test Plan:
- Single transfer:
  - Stimulus: data_in=8'hA5, req_in rise before edge 1, data_ready=1.
  - Response: data_valid after edge 3 with data_out=8'hA5; ack_out=1 after edge 4.
  - Continue: drop req_in before edge 6. Response: ack_out=0 after edge 8, busy=0.
- Consumer stall:
  - Stimulus: as the single transfer, but data_ready=0 for 10 cycles.
  - Response: data_valid and data_out=8'hA5 held stable; ack_out stays 0 until the first edge with data_ready=1.
- Back-to-back:
  - Stimulus: words 8'h01, 8'h02, 8'h03 sent with a 4-phase initiator model whose clock is 3.7x slower.
  - Response: exactly three valid/ready transfers, in order, proto_err=0.
- Protocol violation:
  - Stimulus: req_in pulsed high for 3 cycles with data_ready=0.
  - Response: proto_err=1 and stays 1; the word is still delivered once data_ready=1; ack_out high for 1 cycle then low.
- Reset mid-transfer:
  - Stimulus: assert rst in WAIT_LOW.
  - Response: ack_out, data_valid, busy go 0 asynchronously.
  - Stimulus: release rst with req_in held high.
  - Response: new capture, data_valid after SYNC_STAGES+1 edges.
- SYNC_STAGES=3, DATA_W=32:
  - Stimulus: word 32'hDEADBEEF.
  - Response: data_valid after edge 4 relative to req_in rise before edge 1.
